// File: rtl/apb_slave_regs.sv
// APB responder with a small word-register bank, programmable wait states and
// PSLVERR on bad addresses or writes to the read-only status register.
// The last register reads {err_cnt, write_cnt}; register 0 drives ctrl_out.
module apb_slave_regs #(
    parameter int unsigned             PADDR_WIDTH  = 32,
    parameter int unsigned             PWDATA_WIDTH = 32,
    parameter int unsigned             PRDATA_WIDTH = 32,
    parameter int unsigned             PSEL_INDEX   = 0,
    parameter logic [PADDR_WIDTH-1:0]  BASE_ADDR    = '0,
    parameter int unsigned             NUM_REGS     = 8,
    parameter int unsigned             WAIT_STATES  = 1
) (
    input  logic                    pclock,
    input  logic                    preset,
    input  logic [PADDR_WIDTH-1:0]  paddr,
    input  logic                    prwd,
    input  logic [PWDATA_WIDTH-1:0] pwdata,
    input  logic                    penable,
    input  logic [15:0]             psel,
    output logic [PRDATA_WIDTH-1:0] prdata,
    output logic                    pready,
    output logic                    pslverr,
    output logic [31:0]             ctrl_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [31:0]      regs_q [NUM_REGS];
    logic [15:0]      write_cnt_q;
    logic [15:0]      err_cnt_q;

    logic                   sel;
    logic [PADDR_WIDTH-1:0] off;
    logic [PADDR_WIDTH-1:0] word;
    logic                   addr_ok;
    logic [IDX_W-1:0]       idx;
    logic                   is_status;
    logic                   complete;
    logic                   err;
    logic [31:0]            rd_word;

    assign sel       = psel[PSEL_INDEX];
    assign off       = paddr - BASE_ADDR;
    assign word      = off >> 2;
    assign addr_ok   = (off[1:0] == 2'b00) && (word < PADDR_WIDTH'(NUM_REGS));
    assign idx       = off[IDX_W+1:2];
    assign is_status = (idx == IDX_W'(NUM_REGS - 1));

    // Completion is gated by reset so pready never pulses while reset is held.
    assign complete  = preset && (state_q == StAccess) && sel && (cnt_q == 4'd0);
    assign err       = !addr_ok || (prwd && is_status);

    // Read mux: status slot is synthesized from the counters, not stored.
    always_comb begin
        rd_word = '0;
        if (is_status) begin
            rd_word = {err_cnt_q, write_cnt_q};
        end else begin
            rd_word = regs_q[idx];
        end
    end

    assign pready   = complete;
    assign pslverr  = complete && err;
    assign prdata   = (complete && !err && !prwd) ? PRDATA_WIDTH'(rd_word) : '0;
    assign ctrl_out = regs_q[0];

    // Protocol FSM, wait counter, register bank and event counters.
    always_ff @(posedge pclock) begin
        if (!preset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            write_cnt_q <= '0;
            err_cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (sel && !penable) begin
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    // Anything but a proper access phase drops the transfer silently.
                    if (sel && penable) begin
                        state_q <= StAccess;
                        cnt_q   <= 4'(WAIT_STATES);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StAccess: begin
                    if (!sel) begin
                        state_q <= StIdle;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (complete) begin
                if (err) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_q <= err_cnt_q + 16'd1;
                    end
                end else if (prwd) begin
                    regs_q[idx] <= pwdata[31:0];
                    write_cnt_q <= write_cnt_q + 16'd1;
                end
            end
        end
    end

endmodule
